// File: rtl/cache_pkg.sv
// Shared geometry, FSM states and line layout for the direct-mapped read cache.
// Address layout: | tag | index | word | byte offset |.
package cache_pkg;

    localparam int DATA_W         = 32;
    localparam int TAG_W          = 24;
    localparam int INDEX_W        = 4;
    localparam int WORD_W         = 2;
    localparam int OFF_W          = 2;
    localparam int NUM_LINES      = 16;
    localparam int WORDS_PER_LINE = 4;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    typedef logic [WORDS_PER_LINE-1:0][DATA_W-1:0] block_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        block_t           words;
    } line_t;

endpackage

// File: rtl/cache_mem_model.sv
// Deterministic backing store: every word reads back as its own word address.
// Purely combinational; refill latency is modelled by the cache FSM.
import cache_pkg::*;

module cache_mem_model (
    input  logic [TAG_W-1:0]   tag,
    input  logic [INDEX_W-1:0] index,
    output block_t             words
);

    always_comb begin
        words = '0;
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            words[k] = {tag, index, WORD_W'(k), {OFF_W{1'b0}}};
        end
    end

endmodule

// File: rtl/cache.sv
// Read-only direct-mapped cache, 16 lines x 4 words, with a fixed-latency
// refill from the built-in memory model.
import cache_pkg::*;

module cache #(
    parameter int line_size   = 32,
    parameter int MEM_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [line_size-1:0] address,
    output logic                 busywait,
    output logic [line_size-1:0] data
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    line_t              lines [NUM_LINES];
    line_t              cur;
    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [TAG_W-1:0]   rtag;
    logic [TAG_W-1:0]   rtag_next;
    logic [INDEX_W-1:0] ridx;
    logic [INDEX_W-1:0] ridx_next;
    logic               fill;
    logic               hit;
    block_t             refill;

    logic [TAG_W-1:0]   atag;
    logic [INDEX_W-1:0] aidx;
    logic [WORD_W-1:0]  aword;
    logic               unused_offset;

    assign atag          = address[line_size-1 -: TAG_W];
    assign aidx          = address[OFF_W+WORD_W +: INDEX_W];
    assign aword         = address[OFF_W +: WORD_W];
    assign unused_offset = ^address[OFF_W-1:0];

    assign cur = lines[aidx];

    // An unknown compare falls to the default, so X addresses read as a miss.
    always_comb begin
        hit = 1'b0;
        if (cur.valid && (cur.tag == atag)) begin
            hit = 1'b1;
        end
    end

    cache_mem_model u_mem (
        .tag   (rtag),
        .index (ridx),
        .words (refill)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rtag_next  = rtag;
        ridx_next  = ridx;
        fill       = 1'b0;
        busywait   = 1'b1;
        data       = '0;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    busywait = 1'b0;
                    data     = line_size'(cur.words[aword]);
                end else begin
                    state_next = FETCH;
                    cnt_next   = '0;
                    rtag_next  = atag;
                    ridx_next  = aidx;
                end
            end
            FETCH: begin
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    fill       = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The refill target only needs to be stable while in FETCH.
    always_ff @(posedge clk) begin
        rtag <= rtag_next;
        ridx <= ridx_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                lines[i].valid <= 1'b0;
            end
        end else if (fill) begin
            lines[ridx].valid <= 1'b1;
            lines[ridx].tag   <= rtag;
            lines[ridx].words <= refill;
        end
    end

endmodule

// File: tb/tb_cache.sv
// Self-checking bench for cache: directed scenarios plus random traffic
// against a tag/valid model of the cache contents.
module tb_cache;

    localparam int LAT = 4;
    localparam int MISS_CYC = LAT + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = 32'h0;
    logic        busywait;
    logic [31:0] data;

    int n_assert = 0;
    int n_fail = 0;

    bit          mvalid [16];
    logic [23:0] mtag [16];

    cache #(.line_size(32), .MEM_LATENCY(LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .busywait (busywait),
        .data     (data)
    );

    always #5 clk = ~clk;

    function automatic bit model_hit(input logic [31:0] a);
        return mvalid[a[7:4]] && (mtag[a[7:4]] == a[31:8]);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    task automatic model_fill(input logic [31:0] a);
        mvalid[a[7:4]] = 1'b1;
        mtag[a[7:4]]   = a[31:8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    endtask

    // Apply an address and wait (bounded) until it is served.
    task automatic access(input logic [31:0] a, output int cycles,
                          output logic [31:0] d, output int zbad);
        address = a;
        cycles = 0;
        zbad = 0;
        #1;
        while (busywait !== 1'b0 && cycles <= 20) begin
            if (data !== 32'h0) zbad++;
            @(posedge clk);
            #2;
            cycles++;
        end
        d = data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        address = 32'h8000019E;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        n_assert++;
        if (busywait !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 1", busywait);
        end
        n_assert++;
        if (data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", data);
        end
    endtask

    task automatic test_first_fill();
        int c, z;
        logic [31:0] d;
        access(32'h8000019E, c, d, z);
        model_fill(32'h8000019E);
        n_assert++;
        if (c !== MISS_CYC) begin
            n_fail++;
            $display("FAIL fill_cycles: got %0d expected %0d", c, MISS_CYC);
        end
        n_assert++;
        if (d !== 32'h8000019C) begin
            n_fail++;
            $display("FAIL fill_data: got %h expected 8000019c", d);
        end
        n_assert++;
        if (z !== 0) begin
            n_fail++;
            $display("FAIL fill_zero: got %0d nonzero busy cycles expected 0", z);
        end
    endtask

    task automatic test_hits();
        int c, z;
        logic [31:0] d;
        logic [31:0] addrs [2] = '{32'h80000190, 32'h80000194};
        foreach (addrs[i]) begin
            access(addrs[i], c, d, z);
            n_assert++;
            if (c !== 0 || d !== addrs[i]) begin
                n_fail++;
                $display("FAIL hit_%0d: got cyc=%0d data=%h expected cyc=0 data=%h",
                         i, c, d, addrs[i]);
            end
        end
    endtask

    task automatic test_index0();
        int c, z;
        logic [31:0] d;
        access(32'h00000002, c, d, z);
        model_fill(32'h00000002);
        n_assert++;
        if (c !== MISS_CYC || d !== 32'h0) begin
            n_fail++;
            $display("FAIL index0: got cyc=%0d data=%h expected cyc=%0d data=0",
                     c, d, MISS_CYC);
        end
        access(32'h8000019E, c, d, z);
        n_assert++;
        if (c !== 0 || d !== 32'h8000019C) begin
            n_fail++;
            $display("FAIL index0_back: got cyc=%0d data=%h expected cyc=0 data=8000019c",
                     c, d);
        end
    endtask

    task automatic test_conflict();
        int c, z;
        logic [31:0] d;
        access(32'h9000019C, c, d, z);
        model_fill(32'h9000019C);
        n_assert++;
        if (c !== MISS_CYC || d !== 32'h9000019C) begin
            n_fail++;
            $display("FAIL conflict_new: got cyc=%0d data=%h expected cyc=%0d data=9000019c",
                     c, d, MISS_CYC);
        end
        access(32'h8000019C, c, d, z);
        model_fill(32'h8000019C);
        n_assert++;
        if (c !== MISS_CYC || d !== 32'h8000019C) begin
            n_fail++;
            $display("FAIL conflict_evict: got cyc=%0d data=%h expected cyc=%0d data=8000019c",
                     c, d, MISS_CYC);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int c, z;
        logic [31:0] d;
        address = 32'h12345670;
        #1;
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        n_assert++;
        if (busywait !== 1'b1 || data !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_fetch_out: got busy=%b data=%h expected busy=1 data=0",
                     busywait, data);
        end
        address = 32'h8000019C;
        #1;
        n_assert++;
        if (busywait !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_fetch_cached: got busy=%b expected 1", busywait);
        end
        access(32'h8000019C, c, d, z);
        model_fill(32'h8000019C);
        n_assert++;
        if (c !== MISS_CYC || d !== 32'h8000019C) begin
            n_fail++;
            $display("FAIL rst_fetch_refill: got cyc=%0d data=%h expected cyc=%0d data=8000019c",
                     c, d, MISS_CYC);
        end
        access(32'h12345670, c, d, z);
        model_fill(32'h12345670);
        n_assert++;
        if (c !== MISS_CYC || d !== 32'h12345670) begin
            n_fail++;
            $display("FAIL rst_fetch_aborted: got cyc=%0d data=%h expected cyc=%0d data=12345670",
                     c, d, MISS_CYC);
        end
    endtask

    task automatic test_addr_change();
        int c, z;
        logic [31:0] d;
        logic [31:0] a [2] = '{32'h00000A40, 32'h00000B50};
        logic [31:0] b [2] = '{32'h8000019A, 32'h00000C68};
        for (int v = 0; v < 2; v++) begin
            int exp_c;
            bit b_hit;
            address = a[v];
            #1;
            repeat (2) begin
                @(posedge clk);
                #2;
            end
            model_fill(a[v]);
            b_hit = model_hit(b[v]);
            exp_c = (MISS_CYC - 2) + (b_hit ? 0 : MISS_CYC);
            access(b[v], c, d, z);
            model_fill(b[v]);
            n_assert++;
            if (c !== exp_c || d !== model_word(b[v])) begin
                n_fail++;
                $display("FAIL chg_new_%0d: got cyc=%0d data=%h expected cyc=%0d data=%h",
                         v, c, d, exp_c, model_word(b[v]));
            end
            access(a[v], c, d, z);
            n_assert++;
            if (c !== 0 || d !== model_word(a[v])) begin
                n_fail++;
                $display("FAIL chg_orig_%0d: got cyc=%0d data=%h expected cyc=0 data=%h",
                         v, c, d, model_word(a[v]));
            end
        end
    endtask

    task automatic test_random();
        int c, z;
        logic [31:0] d;
        logic [23:0] pool [4] = '{24'h800001, 24'h900001, 24'h000000, 24'h5A5A5A};
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int exp_c;
            logic [23:0] t;
            t = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) t = 24'($urandom);
            a = {t, 4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom)};
            exp_c = model_hit(a) ? 0 : MISS_CYC;
            access(a, c, d, z);
            model_fill(a);
            n_assert++;
            if (c !== exp_c || d !== model_word(a) || z !== 0) begin
                n_fail++;
                $display("FAIL rand_%0d: addr=%h got cyc=%0d data=%h zbad=%0d expected cyc=%0d data=%h",
                         n, a, c, d, z, exp_c, model_word(a));
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_fill();
        test_hits();
        test_index0();
        test_conflict();
        test_reset_mid_fetch();
        test_addr_change();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
